// File: rtl/jt51_exp_serial.sv
// rtl/jt51_exp_serial.sv - double-buffered YM3012-style DAC serialiser for stereo mantissa/exponent pairs
module jt51_exp_serial #(
    parameter int PAD = 3
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cen,
    input  logic       i_sample,
    input  logic [9:0] i_left_man,
    input  logic [2:0] i_left_exp,
    input  logic [9:0] i_right_man,
    input  logic [2:0] i_right_exp,
    output logic       o_so,
    output logic       o_sh1,
    output logic       o_sh2,
    output logic       o_busy,
    output logic       o_overrun,
    output logic       o_underrun
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Packed sample layout: {left_man, left_exp, right_man, right_exp}
    logic [25:0] r_hold;
    logic        r_pending;
    logic [25:0] r_frame;
    logic [4:0]  r_slot;
    state_t      r_state;

    logic        w_wrap;
    logic        w_load;
    logic        w_consume;
    logic [25:0] w_next_frame;
    logic [4:0]  w_next_slot;
    logic [12:0] w_half;
    logic [15:0] w_half_slots;
    logic        w_next_so;

    // A frame boundary is the cen that takes slot 31 back to 0
    assign w_wrap       = (r_state == ST_RUN) && (r_slot == 5'd31);
    assign w_load       = i_cen && ((r_state == ST_RUN) ? w_wrap : r_pending);
    assign w_consume    = w_load && r_pending;
    assign w_next_frame = w_consume ? r_hold : r_frame;
    assign w_next_slot  = (r_state == ST_RUN) ? (r_slot + 5'd1) : 5'd0;

    // Half-frame bit map: PAD zero slots, then mantissa LSB first, then exponent
    assign w_half       = w_next_slot[4] ? w_next_frame[12:0] : w_next_frame[25:13];
    assign w_half_slots = {w_half[2:0], w_half[12:3], {PAD{1'b0}}};
    assign w_next_so    = w_half_slots[w_next_slot[3:0]];

    // Holding register: latest sample wins; overwrite of an unconsumed sample flags overrun
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold    <= 26'd0;
            r_pending <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= i_sample && r_pending && !w_consume;
            if (i_sample) begin
                r_hold    <= {i_left_man, i_left_exp, i_right_man, i_right_exp};
                r_pending <= 1'b1;
            end else if (w_consume) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Serialiser FSM with registered pin outputs; state moves only on cen
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_slot     <= 5'd0;
            r_frame    <= 26'd0;
            o_so       <= 1'b0;
            o_sh1      <= 1'b0;
            o_sh2      <= 1'b0;
            o_busy     <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            o_underrun <= 1'b0;
            if (i_cen) begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_pending) begin
                            r_state <= ST_RUN;
                            r_slot  <= 5'd0;
                            r_frame <= w_next_frame;
                            o_so    <= w_next_so;
                            o_sh1   <= 1'b1;
                            o_sh2   <= 1'b0;
                            o_busy  <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        r_slot  <= w_next_slot;
                        r_frame <= w_next_frame;
                        o_so    <= w_next_so;
                        o_sh1   <= !w_next_slot[4];
                        o_sh2   <= w_next_slot[4];
                        o_busy  <= 1'b1;
                        // Nothing new at the boundary: the previous sample repeats
                        if (w_wrap && !r_pending) begin
                            o_underrun <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jt51_exp_serial.sv
// tb/tb_jt51_exp_serial.sv - randomized and directed self-checking bench for jt51_exp_serial
module tb_jt51_exp_serial;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_cen = 1'b0;
    logic       i_sample = 1'b0;
    logic [9:0] i_left_man = 10'd0;
    logic [2:0] i_left_exp = 3'd0;
    logic [9:0] i_right_man = 10'd0;
    logic [2:0] i_right_exp = 3'd0;
    logic       o_so, o_sh1, o_sh2, o_busy, o_overrun, o_underrun;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jt51_exp_serial #(.PAD(3)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_cen       (i_cen),
        .i_sample    (i_sample),
        .i_left_man  (i_left_man),
        .i_left_exp  (i_left_exp),
        .i_right_man (i_right_man),
        .i_right_exp (i_right_exp),
        .o_so        (o_so),
        .o_sh1       (o_sh1),
        .o_sh2       (o_sh2),
        .o_busy      (o_busy),
        .o_overrun   (o_overrun),
        .o_underrun  (o_underrun)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endfunction

    // Bit carried in slot s of a frame for the given stereo sample
    function automatic int exp_bit(input int lm, input int le, input int rm, input int re, input int s);
        int p, m, e;
        p = s % 16;
        m = (s < 16) ? lm : rm;
        e = (s < 16) ? le : re;
        if (p < 3) return 0;
        if (p < 13) return (m >> (p - 3)) & 1;
        return (e >> (p - 13)) & 1;
    endfunction

    // Behavioural reference: a one-deep mailbox feeding a 32-slot frame player
    bit m_run = 0, m_pend = 0;
    int m_slot = 0;
    int h_lm = 0, h_le = 0, h_rm = 0, h_re = 0;
    int f_lm = 0, f_le = 0, f_rm = 0, f_re = 0;
    bit e_ovr = 0, e_und = 0;
    bit m_wrap, m_load, m_cons;

    always @(posedge clk) begin
        if (i_rst) begin
            m_run = 0; m_pend = 0; m_slot = 0;
            h_lm = 0; h_le = 0; h_rm = 0; h_re = 0;
            f_lm = 0; f_le = 0; f_rm = 0; f_re = 0;
            e_ovr = 0; e_und = 0;
        end else begin
            m_wrap = m_run && (m_slot == 31);
            m_load = i_cen && (m_run ? m_wrap : m_pend);
            m_cons = m_load && m_pend;
            e_und  = m_run && i_cen && m_wrap && !m_pend;
            e_ovr  = i_sample && m_pend && !m_cons;
            if (m_cons) begin
                f_lm = h_lm; f_le = h_le; f_rm = h_rm; f_re = h_re;
            end
            if (i_sample) begin
                h_lm = i_left_man; h_le = i_left_exp; h_rm = i_right_man; h_re = i_right_exp;
                m_pend = 1;
            end else if (m_cons) begin
                m_pend = 0;
            end
            if (i_cen) begin
                if (m_run) m_slot = (m_slot + 1) % 32;
                else if (m_load) begin m_run = 1; m_slot = 0; end
            end
        end
    end

    bit cmp_en = 0;

    // Every-cycle comparison against the reference
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("so",       o_so,       m_run ? exp_bit(f_lm, f_le, f_rm, f_re, m_slot) : 0);
            chk("sh1",      o_sh1,      m_run && (m_slot < 16));
            chk("sh2",      o_sh2,      m_run && (m_slot >= 16));
            chk("busy",     o_busy,     m_run);
            chk("overrun",  o_overrun,  e_ovr);
            chk("underrun", o_underrun, e_und);
        end
    end

    int n_ovr = 0, n_und = 0;
    always @(negedge clk) begin
        if (o_overrun) n_ovr++;
        if (o_underrun) n_und++;
    end

    task automatic step(input bit c, input bit s);
        i_cen = c;
        i_sample = s;
        @(posedge clk);
        #1;
        i_cen = 0;
        i_sample = 0;
    endtask

    task automatic cenp();
        repeat (3) step(0, 0);
        step(1, 0);
    endtask

    task automatic set_data(input int lm, input int le, input int rm, input int re);
        i_left_man = lm[9:0]; i_left_exp = le[2:0];
        i_right_man = rm[9:0]; i_right_exp = re[2:0];
    endtask

    task automatic adv_to(input int target);
        int n;
        n = 0;
        while (m_slot != target && n < 64) begin
            cenp();
            n++;
        end
        chk("adv_slot_bound", m_slot, target);
    endtask

    int lit_so[32] = '{0,0,0,1,0,1,0,0,1,0,1,0,1,1,0,1,
                       0,0,0,0,1,0,1,1,0,1,0,1,0,0,1,0};
    int b_lm, b_le, b_rm, b_re, c_lm, c_le, c_rm, c_re;

    initial begin
        // Reset, then idle with no samples
        i_rst = 1;
        step(0, 0);
        step(0, 0);
        i_rst = 0;
        cmp_en = 1;
        chk("rst_so", o_so, 0);
        chk("rst_sh1", o_sh1, 0);
        chk("rst_sh2", o_sh2, 0);
        chk("rst_busy", o_busy, 0);
        n_und = 0;
        repeat (100) cenp();
        chk("idle_underruns", n_und, 0);
        chk("idle_busy", o_busy, 0);

        // Single sample, checked against hand-derived bit pattern
        set_data('h2A5, 5, 'h15A, 2);
        step(0, 1);
        for (int s = 0; s < 32; s++) begin
            cenp();
            if (s == 0) chk("first_busy", o_busy, 1);
            chk($sformatf("single_so_s%0d", s), o_so, lit_so[s]);
            chk($sformatf("single_sh1_s%0d", s), o_sh1, (s < 16) ? 1 : 0);
            chk($sformatf("single_sh2_s%0d", s), o_sh2, (s < 16) ? 0 : 1);
        end

        // Underrun: the same frame repeats
        n_und = 0;
        for (int s = 0; s < 32; s++) begin
            cenp();
            chk($sformatf("repeat_so_s%0d", s), o_so, lit_so[s]);
        end
        chk("underrun_count", n_und, 1);
        chk("underrun_busy", o_busy, 1);

        // Overrun: two strobes 3 clk apart in one frame; B must be sent
        repeat (5) cenp();
        n_ovr = 0;
        set_data($urandom_range(0, 1023), $urandom_range(0, 7), $urandom_range(0, 1023), $urandom_range(0, 7));
        step(0, 1);
        step(0, 0);
        step(0, 0);
        b_lm = $urandom_range(0, 1023); b_le = $urandom_range(0, 7);
        b_rm = $urandom_range(0, 1023); b_re = $urandom_range(0, 7);
        set_data(b_lm, b_le, b_rm, b_re);
        step(0, 1);
        step(0, 0);
        chk("overrun_count", n_ovr, 1);
        adv_to(31);
        for (int s = 0; s < 32; s++) begin
            cenp();
            chk($sformatf("ovr_b_so_s%0d", s), o_so, exp_bit(b_lm, b_le, b_rm, b_re, s));
        end

        // Boundary collision: C arrives on the wrap cen while B is pending
        repeat (3) cenp();
        b_lm = $urandom_range(0, 1023); b_le = $urandom_range(0, 7);
        b_rm = $urandom_range(0, 1023); b_re = $urandom_range(0, 7);
        set_data(b_lm, b_le, b_rm, b_re);
        step(0, 1);
        adv_to(31);
        c_lm = $urandom_range(0, 1023); c_le = $urandom_range(0, 7);
        c_rm = $urandom_range(0, 1023); c_re = $urandom_range(0, 7);
        set_data(c_lm, c_le, c_rm, c_re);
        n_ovr = 0;
        n_und = 0;
        step(1, 1);
        for (int s = 0; s < 32; s++) begin
            if (s > 0) cenp();
            chk($sformatf("coll_b_so_s%0d", s), o_so, exp_bit(b_lm, b_le, b_rm, b_re, s));
        end
        for (int s = 0; s < 32; s++) begin
            cenp();
            chk($sformatf("coll_c_so_s%0d", s), o_so, exp_bit(c_lm, c_le, c_rm, c_re, s));
        end
        chk("coll_overruns", n_ovr, 0);
        chk("coll_underruns", n_und, 0);

        // Mid-frame reset at slot 20, then an all-ones sample
        adv_to(20);
        i_rst = 1;
        step(0, 0);
        i_rst = 0;
        chk("mrst_so", o_so, 0);
        chk("mrst_sh1", o_sh1, 0);
        chk("mrst_sh2", o_sh2, 0);
        chk("mrst_busy", o_busy, 0);
        set_data('h3FF, 7, 'h3FF, 7);
        step(0, 1);
        for (int s = 0; s < 16; s++) begin
            cenp();
            chk($sformatf("ones_so_s%0d", s), o_so, (s >= 3) ? 1 : 0);
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            i_rst = ($urandom_range(0, 499) == 0);
            i_cen = $urandom_range(0, 1);
            i_sample = ($urandom_range(0, 29) == 0);
            set_data($urandom_range(0, 1023), $urandom_range(0, 7), $urandom_range(0, 1023), $urandom_range(0, 7));
            @(posedge clk);
            #1;
        end
        i_rst = 0;
        i_cen = 0;
        i_sample = 0;
        @(negedge clk);
        cmp_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jt51_exp_serial.md
Name: jt51_exp_serial

Overview:
- Downstream stage of the linear-to-floating-point converter.
- Takes the left and right 10-bit mantissa / 3-bit exponent pairs and serialises them into the YM3012-style DAC stream: serial data `so`, plus sample-and-hold strobes `sh1` (left) and `sh2` (right).
- Double-buffers incoming samples so the producer and the bit-clock-rate serialiser are decoupled, and flags overrun and underrun.
- Sits at the chip's audio output pins.

Parameters:
- PAD, 3, number of leading zero bit slots in each 16-slot half-frame; PAD + 10 + 3 must equal 16 (fixed at 3, kept as a parameter for documentation and assertion only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cen  in  1  bit-clock enable; all serialiser state advances only on clk edges with cen=1
- sample  in  1  one-cycle strobe: left_man/left_exp/right_man/right_exp valid (any cycle, independent of cen)
- left_man  in  10  left mantissa (two's complement)
- left_exp  in  3  left exponent
- right_man  in  10  right mantissa
- right_exp  in  3  right exponent
- so  out  1  serial data, LSB first
- sh1  out  1  left sample-and-hold strobe
- sh2  out  1  right sample-and-hold strobe
- busy  out  1  1 while in RUN state
- overrun  out  1  one-clk pulse: sample arrived while the previous one was still pending
- underrun  out  1  one-clk pulse: frame started with no pending sample, previous sample repeated

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs: so=0, sh1=0, sh2=0, busy=0, overrun=0, underrun=0.
  - Internal: slot counter=0, pending=0, holding and shift registers=0, state=IDLE.
  - Reset mid-frame aborts the frame immediately; no partial-frame completion.
- Holding register:
  - On any clk with sample=1, capture {left_man, left_exp, right_man, right_exp} and set pending=1.
  - If pending was already 1 and was not being consumed that same cycle: overwrite with the new data (latest wins) and pulse overrun=1 for exactly one clk.
- States:
  - IDLE:
    - Outputs held at 0.
    - On a clk with cen=1 and pending=1: load the shift registers from the holding register, clear pending, enter RUN, slot=0.
  - RUN:
    - On each cen, slot increments modulo 32.
    - On the cen where slot wraps 31->0, start a new frame: if pending=1, load and clear pending; else reload the previous sample and pulse underrun=1 for one clk.
    - RUN is left only by reset.
- Frame layout (slot s, output registered, valid after the cen edge that selects slot s):
  - Left half, s=0..15: s=0..2 -> so=0; s=3..12 -> so=left_man[s-3]; s=13..15 -> so=left_exp[s-13].
  - Right half, s=16..31: same layout with right_man / right_exp at offset 16.
  - sh1=1 for slots 0..15, sh2=1 for slots 16..31; exactly one is high in RUN. The DAC latches on the falling edge of each strobe.
- Simultaneous events:
  - sample=1 on the same clk as a frame-start load: the shift registers take the OLD holding contents, the holding register takes the new data, pending remains 1, no overrun.
  - sample=1 with cen=1 in IDLE: the frame starts on the next cen, not the same one.
- Latency: the first `so` bit of a sample appears on the first cen edge at or after the frame boundary following its capture. Minimum is 1 cen from IDLE.
- Between cen pulses all outputs hold. overrun and underrun are clk-wide pulses, not cen-wide.
- Throughput: one stereo sample per 32 cen.

Test Plan:
- Reset then idle: rst=1 for 2 clk, no sample, 100 cen -> so=sh1=sh2=busy=0 throughout; no underrun pulses.
- Single sample: left_man=10'h2A5, left_exp=3'd5, right_man=10'h15A, right_exp=3'd2, sample pulse, cen every 4 clk.
  - Slots 0-15: so = 0,0,0,1,0,1,0,0,1,0,1,0,1,1,0,1; sh1=1, sh2=0.
  - Slots 16-31: so = 0,0,0,0,1,0,1,1,0,1,0,1,0,0,1,0; sh1=0, sh2=1.
  - busy=1 from the first cen.
- Underrun: no second sample before slot 31->0 -> underrun pulses once, the second frame's bits are identical to the first, busy stays 1.
- Overrun: two sample strobes 3 clk apart within one frame (values A then B) -> overrun pulses once on the second strobe; the next frame serialises B.
- Boundary collision: sample=1 on the exact clk of the 31->0 cen with new value C, pending old value B -> the frame transmits B, pending=1 with C, no overrun; the following frame transmits C.
- Mid-frame reset: rst=1 at slot 20 -> next clk all outputs 0, state IDLE. A new sample with all-ones mantissa 10'h3FF and exp=7 -> slots 3..15 all so=1.
